// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: operand widths, register-file
// constants and state encoding, and ALU control codes.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  // $0 is hardwired to zero
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } regfile_state_t;

  // ALU control codes driven by ALU control
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mips_register_file_if.sv
// Register-file access bundle: two read ports, one write port, and the
// clear-request/busy pair. slave = register file, master = datapath.
interface mips_register_file_if
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
);

  logic [ADDR_W-1:0] Read_reg_1;
  logic [ADDR_W-1:0] Read_reg_2;
  logic [ADDR_W-1:0] Write_reg;
  logic [DATA_W-1:0] Write_data;
  logic              RegWrite;
  logic              Clear_req;
  logic [DATA_W-1:0] Data_1;
  logic [DATA_W-1:0] Data_2;
  logic              Busy;

  modport master (
    output Read_reg_1, Read_reg_2, Write_reg, Write_data, RegWrite, Clear_req,
    input  Data_1, Data_2, Busy
  );

  modport slave (
    input  Read_reg_1, Read_reg_2, Write_reg, Write_data, RegWrite, Clear_req,
    output Data_1, Data_2, Busy
  );

endinterface

// File: rtl/mips_register_file.sv
// 32 x 32 MIPS general-purpose register file: two combinational read
// ports, one clocked write port, $0 hardwired to zero, and a sequential
// clear engine that zeroes one register per cycle while Busy is high.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through to reads.
module mips_register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned NUM_REGS = mips_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  mips_register_file_if.slave rf
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NUM_REGS];

  regfile_state_t    state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic              wr_en;
  logic [DATA_W-1:0] rd_1, rd_2;

  // Writes only land while idle and never target $0
  assign wr_en = rf.RegWrite && (rf.Write_reg != ZERO_IDX) && (state == RF_IDLE);

  // Clear FSM state and sweep index register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Clear FSM next-state: start sweep on request, stop after the last index
  always_comb begin
    state_next = state;
    idx_next   = idx;
    unique case (state)
      RF_IDLE: begin
        if (rf.Clear_req) begin
          state_next = RF_CLEAR;
          idx_next   = '0;
        end
      end
      RF_CLEAR: begin
        if (idx == LAST_IDX) begin
          state_next = RF_IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: begin
        state_next = RF_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Register array: reset clears all, sweep clears one per cycle, else write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[ADDR_W'(i)] <= '0;
      end
    end else if (state == RF_CLEAR) begin
      regs[idx] <= '0;
    end else if (wr_en) begin
      regs[rf.Write_reg] <= rf.Write_data;
    end
  end

  // Combinational read ports with $0 forced to zero
  always_comb begin
    rd_1 = (rf.Read_reg_1 == ZERO_IDX) ? '0 : regs[rf.Read_reg_1];
    rd_2 = (rf.Read_reg_2 == ZERO_IDX) ? '0 : regs[rf.Read_reg_2];
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes $0 and the sweep, so $0 stays zero here
    if (wr_en && (rf.Read_reg_1 == rf.Write_reg)) rd_1 = rf.Write_data;
    if (wr_en && (rf.Read_reg_2 == rf.Write_reg)) rd_2 = rf.Write_data;
`endif
  end

  assign rf.Data_1 = rd_1;
  assign rf.Data_2 = rd_2;
  assign rf.Busy   = (state == RF_CLEAR);

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed scenarios then a
// randomized phase, all checked against a behavioural array model.
module tb_mips_register_file;

  logic clk;
  logic reset;

  mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) rf_bus ();

  mips_register_file #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: array contents plus number of sweep cycles remaining
  logic [31:0] mdl [32];
  int          clr_left;
  int          n_cmp;
  int          n_err;
  int          busy_seen;

  function automatic logic [31:0] mdl_read(input logic [4:0] ra);
    logic [31:0] v;
    v = (ra == 5'd0) ? 32'h0 : mdl[ra];
`ifdef REGFILE_BYPASS_EN
    if (rf_bus.RegWrite && rf_bus.Write_reg != 5'd0 && clr_left == 0 &&
        ra == rf_bus.Write_reg)
      v = rf_bus.Write_data;
`endif
    return v;
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      clr_left = 0;
    end else if (clr_left > 0) begin
      mdl[32 - clr_left] = 32'h0;
      clr_left = clr_left - 1;
    end else begin
      if (rf_bus.RegWrite && rf_bus.Write_reg != 5'd0)
        mdl[rf_bus.Write_reg] = rf_bus.Write_data;
      if (rf_bus.Clear_req) clr_left = 32;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance one edge and update the model
  task automatic step();
    #3;
    check("data_1", rf_bus.Data_1, mdl_read(rf_bus.Read_reg_1));
    check("data_2", rf_bus.Data_2, mdl_read(rf_bus.Read_reg_2));
    check("busy", {31'h0, rf_bus.Busy}, {31'h0, (clr_left > 0)});
    if (rf_bus.Busy === 1'b1) busy_seen++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rf_bus.RegWrite   = 1'b0;
    rf_bus.Clear_req  = 1'b0;
    rf_bus.Write_reg  = 5'd0;
    rf_bus.Write_data = 32'h0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf_bus.RegWrite   = 1'b1;
    rf_bus.Write_reg  = a;
    rf_bus.Write_data = d;
  endtask

  task automatic fill_regs();
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i) * 32'h01010101);
      rf_bus.Read_reg_1 = 5'($urandom_range(0, 31));
      rf_bus.Read_reg_2 = 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    busy_seen = 0;
    clr_left = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    reset = 1'b1;
    idle_inputs();
    rf_bus.Read_reg_1 = 5'd0;
    rf_bus.Read_reg_2 = 5'd0;
    @(posedge clk);
    model_edge();
    #1;
    step();
    reset = 1'b0;

    // Reset state: every index reads zero on both ports
    for (int i = 0; i < 32; i++) begin
      rf_bus.Read_reg_1 = 5'(i);
      rf_bus.Read_reg_2 = 5'(31 - i);
      step();
    end

    // Basic write then read on both ports
    wr(5'd8, 32'hDEADBEEF);
    rf_bus.Read_reg_1 = 5'd8;
    step();
    idle_inputs();
    rf_bus.Read_reg_1 = 5'd8;
    rf_bus.Read_reg_2 = 5'd8;
    step();
    check("reg8_direct", rf_bus.Data_1, 32'hDEADBEEF);

    // Write to $0 is discarded
    wr(5'd0, 32'h12345678);
    rf_bus.Read_reg_1 = 5'd0;
    step();
    idle_inputs();
    step();

    // Same-cycle read/write of reg 9
    wr(5'd9, 32'hA5A5A5A5);
    rf_bus.Read_reg_1 = 5'd9;
    rf_bus.Read_reg_2 = 5'd8;
    step();
    idle_inputs();
    step();

    // Fill, then sweep with a dropped write and an ignored second request
    fill_regs();
    rf_bus.Clear_req = 1'b1;
    step();
    rf_bus.Clear_req = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 36; c++) begin
      idle_inputs();
      if (c == 3) wr(5'd5, 32'hCAFEF00D);
      if (c == 10) rf_bus.Clear_req = 1'b1;
      rf_bus.Read_reg_1 = 5'(c);
      rf_bus.Read_reg_2 = 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    check("busy_cycles", 32'(busy_seen), 32'd32);
    rf_bus.Read_reg_1 = 5'd5;
    step();

    // Reset mid-sweep aborts and zeroes everything
    fill_regs();
    rf_bus.Clear_req = 1'b1;
    step();
    rf_bus.Clear_req = 1'b0;
    for (int c = 0; c < 15; c++) begin
      rf_bus.Read_reg_1 = 5'(c + 16);
      rf_bus.Read_reg_2 = 5'(c);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf_bus.Read_reg_1 = 5'(i);
      rf_bus.Read_reg_2 = 5'(i + 16);
      step();
    end
    wr(5'd3, 32'h00000003);
    step();
    idle_inputs();
    rf_bus.Read_reg_1 = 5'd3;
    rf_bus.Read_reg_2 = 5'd3;
    step();
    check("reg3_after_reset", rf_bus.Data_2, 32'h00000003);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset             = ($urandom_range(0, 99) == 0);
      rf_bus.RegWrite   = $urandom_range(0, 1) == 1;
      rf_bus.Write_reg  = 5'($urandom_range(0, 31));
      rf_bus.Write_data = $urandom;
      rf_bus.Clear_req  = ($urandom_range(0, 39) == 0);
      rf_bus.Read_reg_1 = ($urandom_range(0, 3) == 0) ? rf_bus.Write_reg
                                                       : 5'($urandom_range(0, 31));
      rf_bus.Read_reg_2 = ($urandom_range(0, 3) == 0) ? rf_bus.Write_reg
                                                       : 5'($urandom_range(0, 31));
      step();
    end
    reset = 1'b0;
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
